// File: rtl/poly1305_stream_mac.sv
// Streaming Poly1305 MAC engine: raw RFC 8439 Poly1305 or the AEAD MAC construction
// with per-segment zero padding, length block and a digit-serial acc*r multiplier.
module poly1305_stream_mac #(
  parameter int unsigned DIGIT_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         mode,
  input  logic [255:0] key,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [4:0]   in_bytes,
  input  logic         in_seg,
  input  logic         in_last,
  output logic [127:0] tag,
  output logic         tag_valid,
  output logic         busy,
  output logic         err
);
  localparam int unsigned NDIG = 128 / DIGIT_W;
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(NDIG - 1);
  localparam logic [127:0]  CLAMP   = 128'h0ffffffc0ffffffc0ffffffc0fffffff;
  localparam logic [130:0]  P       = {3'b011, {124{1'b1}}, 4'hb};

  typedef enum logic [2:0] {IDLE, ACCEPT, MUL, RED, LEN, FIN, DONE, ERR} state_t;

  state_t        state_q, state_nxt;
  logic          mode_q, last_q, len_q, seg_text_q, red_ph_q;
  logic [127:0]  r_q, s_q;
  logic [130:0]  acc_q;
  logic [258:0]  prod_q;
  logic [CW-1:0] cnt_q;
  logic [63:0]   aad_len_q, txt_len_q;

  logic                 start_ok, hs, bad;
  logic [127:0]         data_m;
  logic [128:0]         m_blk;
  logic [130:0]         acc_add, acc_len, fold2, red_sub, fin_acc, hi2;
  logic [131:0]         fold1;
  logic [DIGIT_W-1:0]   r_dig;
  logic [130+DIGIT_W:0] pp;
  logic [258:0]         prod_nxt;

  always_comb begin
    data_m = '0;
    for (int unsigned i = 0; i < 16; i++)
      if (i < {27'b0, in_bytes}) data_m[8*i +: 8] = in_data[8*i +: 8];
  end

  assign m_blk   = mode_q ? {1'b1, data_m} : ({1'b0, data_m} | (129'b1 << (8 * in_bytes)));
  assign acc_add = acc_q + {2'b00, m_blk};
  assign acc_len = acc_q + {3'b001, txt_len_q, aad_len_q};

  // MSB-first digits of r: prod = prod * 2^DIGIT_W + acc * digit
  assign r_dig    = r_q[32'(cnt_q) * DIGIT_W +: DIGIT_W];
  assign pp       = {{DIGIT_W{1'b0}}, acc_q} * {131'b0, r_dig};
  assign prod_nxt = (prod_q << DIGIT_W) + 259'(pp);

  // 2^130 == 5 (mod p): two folds leave a value below 2^130 + 5
  assign fold1   = {2'b00, prod_q[129:0]} + {1'b0, prod_q[258:130], 2'b00} + {3'b000, prod_q[258:130]};
  assign hi2     = {129'b0, fold1[131:130]};
  assign fold2   = {1'b0, fold1[129:0]} + {hi2[128:0], 2'b00} + hi2;
  assign red_sub = (acc_q >= P) ? acc_q - P : acc_q;
  assign fin_acc = (state_q == RED) ? red_sub : acc_q;

  assign bad = (in_bytes > 5'd16)
            || (in_bytes == 5'd0 && !in_last)
            || (!mode_q && in_bytes != 5'd16 && !in_last)
            || (mode_q && seg_text_q && !in_seg);
  assign hs  = (state_q == ACCEPT) && in_valid && !bad && (in_bytes != 5'd0);

  assign in_ready  = (state_q == ACCEPT);
  assign busy      = (state_q == ACCEPT) || (state_q == MUL) || (state_q == RED) || (state_q == LEN);
  assign tag_valid = (state_q == FIN);

  always_comb begin
    state_nxt = state_q;
    start_ok  = 1'b0;
    case (state_q)
      IDLE, DONE, ERR: if (start) begin
        start_ok  = 1'b1;
        state_nxt = ACCEPT;
      end
      ACCEPT: if (in_valid) begin
        if (bad)                    state_nxt = ERR;
        else if (in_bytes == 5'd0)  state_nxt = mode_q ? LEN : FIN;
        else                        state_nxt = MUL;
      end
      MUL: if (cnt_q == '0) state_nxt = RED;
      RED: if (red_ph_q) begin
        if (len_q)        state_nxt = FIN;
        else if (!last_q) state_nxt = ACCEPT;
        else if (mode_q)  state_nxt = LEN;
        else              state_nxt = FIN;
      end
      LEN:     state_nxt = MUL;
      FIN:     state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= 1'b0;
      last_q     <= 1'b0;
      len_q      <= 1'b0;
      seg_text_q <= 1'b0;
      red_ph_q   <= 1'b0;
      r_q        <= '0;
      s_q        <= '0;
      acc_q      <= '0;
      prod_q     <= '0;
      cnt_q      <= '0;
      aad_len_q  <= '0;
      txt_len_q  <= '0;
      err        <= 1'b0;
      tag        <= '0;
    end else begin
      if (start_ok) begin
        mode_q     <= mode;
        s_q        <= key[255:128];
        r_q        <= key[127:0] & CLAMP;
        acc_q      <= '0;
        aad_len_q  <= '0;
        txt_len_q  <= '0;
        err        <= 1'b0;
        last_q     <= 1'b0;
        len_q      <= 1'b0;
        seg_text_q <= 1'b0;
        red_ph_q   <= 1'b0;
      end else begin
        case (state_q)
          ACCEPT: begin
            if (in_valid && bad) err <= 1'b1;
            if (hs) begin
              acc_q  <= acc_add;
              prod_q <= '0;
              cnt_q  <= CNT_TOP;
              last_q <= in_last;
              if (mode_q) begin
                if (in_seg) begin
                  txt_len_q  <= txt_len_q + {59'b0, in_bytes};
                  seg_text_q <= 1'b1;
                end else begin
                  aad_len_q <= aad_len_q + {59'b0, in_bytes};
                end
              end
            end
          end
          MUL: begin
            prod_q <= prod_nxt;
            cnt_q  <= cnt_q - CW'(1);
          end
          RED: begin
            red_ph_q <= !red_ph_q;
            acc_q    <= red_ph_q ? red_sub : fold2;
          end
          LEN: begin
            acc_q  <= acc_len;
            prod_q <= '0;
            cnt_q  <= CNT_TOP;
            len_q  <= 1'b1;
          end
          default: ;
        endcase
      end
      if (state_nxt == FIN) tag <= fin_acc[127:0] + s_q;
    end
  end
endmodule
